aoc_day3_ascii_parser: RTL and testbench

- Upstream stage of the day-3 joltage solver: converts the raw ASCII puzzle byte stream (digits, CR, LF) into a 4-bit digit stream with valid/ready and an end-of-bank marker.
- Holds each digit back by one byte so it can tag the last digit of every bank, checks bank length, and flags malformed input.
- Output feeds the solver's digit input directly.

---
 rtl/aoc_day3_ascii_parser.sv | 117 +++++++++++
 tb/tb_aoc_day3_ascii_parser.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aoc_day3_ascii_parser.sv
// ASCII-to-digit front end for the day-3 joltage solver: digits, CR and LF in, 4-bit digits with end-of-bank tag out.
// Latency: a digit leaves one cycle after the next DIGIT or LF byte is accepted (one-byte holdback to tag the last digit).
// Backpressure: byte_ready = !digit_valid || digit_ready; output fields are held while stalled. Optional AOC_PARSER_LINE_COUNT_EN adds lines_done.
module aoc_day3_ascii_parser #(
  parameter int LINE_LEN = 14,
  parameter int CNT_W    = $clog2(LINE_LEN + 2)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [3:0]  digit_out,
  output logic        digit_last,
  output logic        digit_valid,
  input  logic        digit_ready,
`ifdef AOC_PARSER_LINE_COUNT_EN
  output logic [15:0] lines_done,
`endif
  output logic        len_err,
  output logic        char_err
);

  // Pending-register occupancy states.
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LINE_LEN);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(LINE_LEN + 1);

  logic [0:0]       state;
  logic [3:0]       pending;
  logic [CNT_W-1:0] count;

  logic accept;
  logic is_digit;
  logic is_lf;
  logic is_cr;
  logic is_bad;
  logic emit;

  assign byte_ready = !digit_valid || digit_ready;
  assign accept     = byte_valid && byte_ready;

  assign is_digit = (byte_in >= 8'h30) && (byte_in <= 8'h39);
  assign is_lf    = (byte_in == 8'h0A);
  assign is_cr    = (byte_in == 8'h0D);
  assign is_bad   = !(is_digit || is_lf || is_cr);

  // A held digit leaves only when a following DIGIT or LF proves whether it was the last of its bank.
  assign emit = accept && (state == FULL) && (is_digit || is_lf);

  // Holdback FSM: pending digit and per-bank digit counter (saturates one past LINE_LEN).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= EMPTY;
      pending <= 4'd0;
      count   <= '0;
    end else if (accept) begin
      if (is_digit) begin
        state   <= FULL;
        pending <= byte_in[3:0];   // low nibble of '0'..'9' is the binary digit
        if (count != SAT_C) begin
          count <= count + CNT_W'(1);
        end
      end else if (is_lf) begin
        state <= EMPTY;
        count <= '0;
      end
    end
  end

  // Output register: load on emit, otherwise drop valid once the downstream takes the digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      digit_valid <= 1'b0;
      digit_out   <= 4'd0;
      digit_last  <= 1'b0;
    end else if (emit) begin
      digit_valid <= 1'b1;
      digit_out   <= pending;
      digit_last  <= is_lf;
    end else if (digit_ready) begin
      digit_valid <= 1'b0;
    end
  end

  // Sticky error flags; neither stalls the stream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_err  <= 1'b0;
      char_err <= 1'b0;
    end else begin
      if (accept && is_bad) begin
        char_err <= 1'b1;
      end
      if (accept && is_digit && (count == LEN_C)) begin
        len_err <= 1'b1;
      end
      if (emit && is_lf && (count != LEN_C)) begin
        len_err <= 1'b1;
      end
    end
  end

`ifdef AOC_PARSER_LINE_COUNT_EN
  // Count banks closed by an LF that emitted a last digit; blank lines do not count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lines_done <= 16'd0;
    end else if (emit && is_lf) begin
      lines_done <= lines_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aoc_day3_ascii_parser.sv
// Directed bench for aoc_day3_ascii_parser: LINE_LEN=14 main instance plus a LINE_LEN=3 instance.
// Both instances see the same byte stream; the LINE_LEN=3 one always accepts digits.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_aoc_day3_ascii_parser;

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [3:0] digit_out;
  logic       digit_last;
  logic       digit_valid;
  logic       digit_ready;
  logic       len_err;
  logic       char_err;

  logic       byte_ready3;
  logic [3:0] digit_out3;
  logic       digit_last3;
  logic       digit_valid3;
  logic       len_err3;
  logic       char_err3;

`ifdef AOC_PARSER_LINE_COUNT_EN
  logic [15:0] lines_done;
  logic [15:0] lines_done3;
`endif

  int errors = 0;
  int checks = 0;

  logic [4:0] q14[$];
  logic [4:0] q3[$];

  aoc_day3_ascii_parser #(.LINE_LEN(14)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .digit_out(digit_out), .digit_last(digit_last), .digit_valid(digit_valid), .digit_ready(digit_ready),
`ifdef AOC_PARSER_LINE_COUNT_EN
    .lines_done(lines_done),
`endif
    .len_err(len_err), .char_err(char_err)
  );

  aoc_day3_ascii_parser #(.LINE_LEN(3)) dut3 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready3),
    .digit_out(digit_out3), .digit_last(digit_last3), .digit_valid(digit_valid3), .digit_ready(1'b1),
`ifdef AOC_PARSER_LINE_COUNT_EN
    .lines_done(lines_done3),
`endif
    .len_err(len_err3), .char_err(char_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every digit transfer as {last, digit}; the transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (rst && digit_valid && digit_ready) q14.push_back({digit_last, digit_out});
    if (rst && digit_valid3) q3.push_back({digit_last3, digit_out3});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the digits captured since index base against s, with last set only on the final digit.
  task automatic check_stream(input string tag, input bit use3, input int base, input string s);
    logic [4:0] cq[$];
    logic [4:0] exp;
    int n;
    cq = use3 ? q3 : q14;
    n = cq.size() - base;
    check({tag, ".count"}, n, s.len());
    for (int i = 0; i < s.len() && i < n; i++) begin
      exp = {(i == s.len() - 1) ? 1'b1 : 1'b0, 4'(s[i] - 8'h30)};
      check($sformatf("%s.d%0d", tag, i), cq[base + i], exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_in = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int base;

  initial begin
    rst = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    digit_ready = 1'b1;
    idle(3);

    // Reset state while rst is held low.
    @(negedge clk);
    check("rst.digit_valid", digit_valid, 1'b0);
    check("rst.digit_out", digit_out, 4'd0);
    check("rst.digit_last", digit_last, 1'b0);
    check("rst.len_err", len_err, 1'b0);
    check("rst.char_err", char_err, 1'b0);
    check("rst.byte_ready", byte_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Nominal bank, LF terminated, back to back.
    base = q14.size();
    send_str("36478936584634\n");
    idle(4);
    check_stream("line_lf", 1'b0, base, "36478936584634");
    check("line_lf.len_err", len_err, 1'b0);
    check("line_lf.char_err", char_err, 1'b0);

    // CRLF ending followed by a blank line.
    do_reset();
    base = q14.size();
    send_str("36478936584634\r\n\n");
    idle(4);
    check_stream("line_crlf", 1'b0, base, "36478936584634");
    check("line_crlf.len_err", len_err, 1'b0);
    check("line_crlf.char_err", char_err, 1'b0);
`ifdef AOC_PARSER_LINE_COUNT_EN
    check("line_crlf.lines_done", lines_done, 16'd1);
`endif

    // Downstream stall mid-line: after "36478" accepted, 7 sits in the output register.
    do_reset();
    base = q14.size();
    send_str("36478");
    digit_ready = 1'b0;
    byte_in = "9";
    byte_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall.byte_ready", byte_ready, 1'b0);
      check("stall.digit_out", digit_out, 4'd7);
    end
    @(posedge clk);
    #1;
    digit_ready = 1'b1;
    send_str("936584634\n");
    idle(4);
    check_stream("stall", 1'b0, base, "36478936584634");

    // Short bank.
    do_reset();
    base = q14.size();
    send_str("123\n");
    idle(4);
    check_stream("short", 1'b0, base, "123");
    check("short.len_err", len_err, 1'b1);

    // Overlong bank: 15 digits, all still emitted.
    do_reset();
    base = q14.size();
    send_str("123456789012345\n");
    idle(4);
    check_stream("long", 1'b0, base, "123456789012345");
    check("long.len_err", len_err, 1'b1);
    check("long.char_err", char_err, 1'b0);

    // Illegal character on the LINE_LEN=3 instance.
    do_reset();
    base = q3.size();
    send_str("12x4\n");
    idle(4);
    check_stream("badchr", 1'b1, base, "124");
    check("badchr.char_err", char_err3, 1'b1);
    check("badchr.len_err", len_err3, 1'b0);

    // Reset mid-bank discards "98" state; only the following ones count.
    do_reset();
    send_str("98");
    idle(2);
    do_reset();
    base = q14.size();
    send_str("11111111111111\n");
    idle(4);
    check_stream("midrst", 1'b0, base, "11111111111111");
    check("midrst.len_err", len_err, 1'b0);
    check("midrst.char_err", char_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
